// File: rtl/meter_cmd_arbiter.sv
// rtl/meter_cmd_arbiter.sv - button sync/debounce, request queue and fixed-priority command issue
// Optional feature macro: METER_CMD_RST_FLUSH_EN (accepted RST1/RST2 command flushes queued add requests)
module meter_cmd_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn_raw,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [5:0] pending,
    output logic [7:0] drop_cnt
);
    localparam int              DW        = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam int              HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [5:0]    r_sync [SYNC_STAGES];
    logic [DW-1:0] r_deb_cnt [6];
    logic [5:0]    r_db;
    logic [5:0]    r_db_q;
    logic [5:0]    r_press;
    logic [5:0]    r_pending;
    logic [7:0]    r_drop_cnt;
    logic          r_cmd_valid;
    logic [2:0]    r_cmd_code;
    logic [1:0]    r_state;
    logic [HW-1:0] r_hold_cnt;

    logic [5:0]    w_s;
    logic [5:0]    w_grant_bit;
    logic [2:0]    w_grant_code;
    logic [5:0]    w_grant_clr;
    logic [5:0]    w_keep;
    logic [5:0]    w_drop;
    logic [5:0]    w_pend_nxt;
    logic [2:0]    w_drop_n;
    logic [8:0]    w_drop_sum;
    logic          w_flush;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain for the raw buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Per-bit debounce: level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) r_deb_cnt[i] <= '0;
            r_db <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_s[i] == r_db[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_db[i]      <= w_s[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising-edge detect of the debounced level, registered as a one-cycle press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_q  <= '0;
            r_press <= '0;
        end else begin
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
        end
    end

    // Fixed priority pick: rst1, rst2, add1, add2, add3, add4
    always_comb begin
        w_grant_bit  = '0;
        w_grant_code = 3'd0;
        if (r_pending[4])      begin w_grant_bit = 6'b010000; w_grant_code = 3'd1; end
        else if (r_pending[5]) begin w_grant_bit = 6'b100000; w_grant_code = 3'd2; end
        else if (r_pending[0]) begin w_grant_bit = 6'b000001; w_grant_code = 3'd3; end
        else if (r_pending[1]) begin w_grant_bit = 6'b000010; w_grant_code = 3'd4; end
        else if (r_pending[2]) begin w_grant_bit = 6'b000100; w_grant_code = 3'd5; end
        else if (r_pending[3]) begin w_grant_bit = 6'b001000; w_grant_code = 3'd6; end
    end

    assign w_grant_clr = (r_state == S_IDLE) ? w_grant_bit : 6'b0;

`ifdef METER_CMD_RST_FLUSH_EN
    assign w_flush = r_cmd_valid & cmd_ready & ((r_cmd_code == 3'd1) | (r_cmd_code == 3'd2));
`else
    assign w_flush = 1'b0;
`endif

    // Next pending set and lost-press count; a grant frees the slot for a same-cycle press
    always_comb begin
        w_keep     = r_pending & ~w_grant_clr;
        w_drop     = r_press & w_keep;
        w_pend_nxt = w_keep | r_press;
        if (w_flush) begin
            w_pend_nxt[3:0] = 4'b0;
            w_drop[3:0]     = 4'b0;
        end
        w_drop_n = 3'd0;
        for (int i = 0; i < 6; i++) w_drop_n = w_drop_n + {2'b0, w_drop[i]};
        w_drop_sum = {1'b0, r_drop_cnt} + {6'b0, w_drop_n};
    end

    // Pending register and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // Command FSM: grant from idle, hold the offer until accepted, then hold off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending != 6'b0) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_code  <= w_grant_code;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_code  <= 3'd0;
                        r_hold_cnt  <= '0;
                        r_state     <= (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) r_state <= S_IDLE;
                    else                         r_hold_cnt <= r_hold_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign pending   = r_pending;
    assign drop_cnt  = r_drop_cnt;
endmodule
